// File: rtl/vram_scanout.sv
// rtl/vram_scanout.sv - 640x480 VGA scanout of the 128x64 2bpp VRAM as a scaled, centred window.
// Optional SCANLINE_EN halves the intensity of the last screen line of every VRAM row.
module vram_scanout #(
   parameter int          H_ACTIVE = 640,
   parameter int          H_FP     = 16,
   parameter int          H_SYNC   = 96,
   parameter int          H_BP     = 48,
   parameter int          V_ACTIVE = 480,
   parameter int          V_FP     = 10,
   parameter int          V_SYNC   = 2,
   parameter int          V_BP     = 33,
   parameter int          SCALE    = 4,
   parameter int          X_OFF    = 64,
   parameter int          Y_OFF    = 112,
   parameter logic [11:0] BORDER   = 12'h222
) (
   input  logic       i_clk,
   input  logic       i_reset,
   output logic [6:0] o_vram_hpos,
   output logic [5:0] o_vram_vpos,
   input  logic [1:0] i_vram_pixelo,
   output logic       o_vga_hs,
   output logic       o_vga_vs,
   output logic       o_vga_de,
   output logic [3:0] o_vga_r,
   output logic [3:0] o_vga_g,
   output logic [3:0] o_vga_b,
   output logic       o_vblank
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW      = $clog2(H_TOTAL);
   localparam int VW      = $clog2(V_TOTAL);
   localparam int SW      = (SCALE > 1) ? $clog2(SCALE) : 1;

   localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
   localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [HW-1:0] X_BEG  = HW'(X_OFF);
   localparam logic [HW-1:0] X_END  = HW'(X_OFF + 128 * SCALE);
   localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
   localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [VW-1:0] Y_BEG  = VW'(Y_OFF);
   localparam logic [VW-1:0] Y_END  = VW'(Y_OFF + 64 * SCALE);
   localparam logic [SW-1:0] S_LAST = SW'(SCALE - 1);

   logic [HW-1:0] r_h;
   logic [VW-1:0] r_v;
   logic [SW-1:0] r_sx, r_sy;
   logic [6:0]    r_hpos;
   logic [5:0]    r_vpos;
   logic          r_hs1, r_vs1, r_act1, r_win1, r_vb1;
   logic          r_hs2, r_vs2, r_de2, r_vb2;
   logic [11:0]   r_rgb;
   logic [3:0]    w_chan;
   logic [11:0]   w_rgb;

   wire w_h_wrap = (r_h == H_LAST);
   wire w_in_act = (r_h < H_ACT) && (r_v < V_ACT);
   wire w_in_wy  = (r_v >= Y_BEG) && (r_v < Y_END);
   wire w_in_win = (r_h >= X_BEG) && (r_h < X_END) && w_in_wy;
   wire w_hs     = !((r_h >= HS_BEG) && (r_h < HS_END));
   wire w_vs     = !((r_v >= VS_BEG) && (r_v < VS_END));
   wire w_vb     = (r_h == '0) && (r_v == V_ACT);

   // Sub-counters step the VRAM address every SCALE pixels/lines instead of dividing.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_h    <= '0;
         r_v    <= '0;
         r_sx   <= '0;
         r_sy   <= '0;
         r_hpos <= '0;
         r_vpos <= '0;
      end else begin
         if (w_h_wrap) begin
            r_h <= '0;
            r_v <= (r_v == V_LAST) ? '0 : r_v + 1'b1;
         end else begin
            r_h <= r_h + 1'b1;
         end
         if (w_in_win) begin
            if (r_sx == S_LAST) begin
               r_sx   <= '0;
               r_hpos <= r_hpos + 1'b1;
            end else begin
               r_sx <= r_sx + 1'b1;
            end
         end else begin
            r_sx   <= '0;
            r_hpos <= '0;
         end
         if (w_h_wrap) begin
            if (w_in_wy) begin
               if (r_sy == S_LAST) begin
                  r_sy   <= '0;
                  r_vpos <= r_vpos + 1'b1;
               end else begin
                  r_sy <= r_sy + 1'b1;
               end
            end else begin
               r_sy   <= '0;
               r_vpos <= '0;
            end
         end
      end
   end

   assign o_vram_hpos = w_in_win ? r_hpos : '0;
   assign o_vram_vpos = w_in_win ? r_vpos : '0;

`ifdef SCANLINE_EN
   logic r_dim1;
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) r_dim1 <= 1'b0;
      else         r_dim1 <= (r_sy == S_LAST);
   end
`endif

   // Stage 1: the VRAM read data lands while these delayed flags are current.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_hs1  <= 1'b1;
         r_vs1  <= 1'b1;
         r_act1 <= 1'b0;
         r_win1 <= 1'b0;
         r_vb1  <= 1'b0;
      end else begin
         r_hs1  <= w_hs;
         r_vs1  <= w_vs;
         r_act1 <= w_in_act;
         r_win1 <= w_in_win;
         r_vb1  <= w_vb;
      end
   end

   always_comb begin
      w_chan = {i_vram_pixelo, i_vram_pixelo};
`ifdef SCANLINE_EN
      if (r_dim1) w_chan = {1'b0, w_chan[3:1]};
`endif
      w_rgb = '0;
      if (r_win1)      w_rgb = {w_chan, w_chan, w_chan};
      else if (r_act1) w_rgb = BORDER;
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_hs2 <= 1'b1;
         r_vs2 <= 1'b1;
         r_de2 <= 1'b0;
         r_vb2 <= 1'b0;
         r_rgb <= '0;
      end else begin
         r_hs2 <= r_hs1;
         r_vs2 <= r_vs1;
         r_de2 <= r_act1;
         r_vb2 <= r_vb1;
         r_rgb <= w_rgb;
      end
   end

   assign o_vga_hs = r_hs2;
   assign o_vga_vs = r_vs2;
   assign o_vga_de = r_de2;
   assign o_vga_r  = r_rgb[11:8];
   assign o_vga_g  = r_rgb[7:4];
   assign o_vga_b  = r_rgb[3:0];
   assign o_vblank = r_vb2;

endmodule

// File: tb/tb_vram_scanout.sv
// tb/tb_vram_scanout.sv - scoreboard bench for vram_scanout on two reduced-timing instances.
module tb_vram_scanout;

   typedef struct {
      int ha, fp, sy, bp, va, vfp, vsy, vbp, sc, xo, yo, pat;
   } geo_t;

   geo_t ga = '{160, 4, 8, 8, 80, 2, 2, 3, 1, 16, 8, 0};
   geo_t gb = '{288, 4, 8, 8, 136, 2, 2, 3, 2, 16, 4, 1};

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [6:0] a_hpos, b_hpos;
   logic [5:0] a_vpos, b_vpos;
   logic [1:0] a_pix, b_pix;
   logic       a_hs, a_vs, a_de, a_vb, b_hs, b_vs, b_de, b_vb;
   logic [3:0] a_r, a_g, a_b, b_r, b_g, b_b;

   vram_scanout #(.H_ACTIVE(160), .H_FP(4), .H_SYNC(8), .H_BP(8),
                  .V_ACTIVE(80), .V_FP(2), .V_SYNC(2), .V_BP(3),
                  .SCALE(1), .X_OFF(16), .Y_OFF(8), .BORDER(12'h222)) dut_a (
      .i_clk(clk), .i_reset(rst), .o_vram_hpos(a_hpos), .o_vram_vpos(a_vpos),
      .i_vram_pixelo(a_pix), .o_vga_hs(a_hs), .o_vga_vs(a_vs), .o_vga_de(a_de),
      .o_vga_r(a_r), .o_vga_g(a_g), .o_vga_b(a_b), .o_vblank(a_vb));

   vram_scanout #(.H_ACTIVE(288), .H_FP(4), .H_SYNC(8), .H_BP(8),
                  .V_ACTIVE(136), .V_FP(2), .V_SYNC(2), .V_BP(3),
                  .SCALE(2), .X_OFF(16), .Y_OFF(4), .BORDER(12'h222)) dut_b (
      .i_clk(clk), .i_reset(rst), .o_vram_hpos(b_hpos), .o_vram_vpos(b_vpos),
      .i_vram_pixelo(b_pix), .o_vga_hs(b_hs), .o_vga_vs(b_vs), .o_vga_de(b_de),
      .o_vga_r(b_r), .o_vga_g(b_g), .o_vga_b(b_b), .o_vblank(b_vb));

   function automatic logic [1:0] pat_px(int sel, int x, int y);
      if (sel == 0) return (x == 0 && y == 0) ? 2'b11 : 2'b00;
      return 2'((x + y) & 3);
   endfunction

   function automatic logic in_win(geo_t g, int h, int v);
      return h >= g.xo && h < g.xo + 128 * g.sc && v >= g.yo && v < g.yo + 64 * g.sc;
   endfunction

   // {hs, vs, de, rgb[11:0], vblank} for the counter state n clocks after release.
   function automatic logic [15:0] exp_out(geo_t g, int n);
      int ht, vt, h, v;
      logic [1:0] px;
      logic [3:0] c;
      logic hs, vs, de, vb;
      logic [11:0] rgb;
      if (n < 0) return 16'hC000;
      ht = g.ha + g.fp + g.sy + g.bp;
      vt = g.va + g.vfp + g.vsy + g.vbp;
      h = n % ht;
      v = (n / ht) % vt;
      hs = !(h >= g.ha + g.fp && h < g.ha + g.fp + g.sy);
      vs = !(v >= g.va + g.vfp && v < g.va + g.vfp + g.vsy);
      de = h < g.ha && v < g.va;
      vb = (h == 0) && (v == g.va);
      rgb = 12'h000;
      if (in_win(g, h, v)) begin
         px = pat_px(g.pat, (h - g.xo) / g.sc, (v - g.yo) / g.sc);
         c = {px, px};
`ifdef SCANLINE_EN
         if (((v - g.yo) % g.sc) == g.sc - 1) c = c >> 1;
`endif
         rgb = {c, c, c};
      end else if (de) begin
         rgb = 12'h222;
      end
      return {hs, vs, de, rgb, vb};
   endfunction

   function automatic logic [12:0] exp_addr(geo_t g, int n);
      int ht, vt, h, v;
      ht = g.ha + g.fp + g.sy + g.bp;
      vt = g.va + g.vfp + g.vsy + g.vbp;
      h = n % ht;
      v = (n / ht) % vt;
      if (!in_win(g, h, v)) return 13'd0;
      return {7'((h - g.xo) / g.sc), 6'((v - g.yo) / g.sc)};
   endfunction

   int tests = 0;
   int fails = 0;
   int ka = 0;
   int phase = 0;
   int first_hs = -1;
   int vs_low = 0;
   int vb_k[$];
   logic [28:0] qa[$], qb[$];

   task automatic check(string nm, logic [28:0] got, logic [28:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s k=%0d got %h exp %h", nm, ka, got, exp);
      end
   endtask

   // VRAM read port: data one clock after the address.
   always @(posedge clk) begin
      a_pix <= pat_px(ga.pat, int'(a_hpos), int'(a_vpos));
      b_pix <= pat_px(gb.pat, int'(b_hpos), int'(b_vpos));
   end

   // Expected-response producer: outputs for state k-2, address for state k.
   always @(posedge clk) begin
      if (rst) begin
         ka = 0;
      end else begin
         ka++;
         qa.push_back({exp_out(ga, ka - 2), exp_addr(ga, ka)});
         qb.push_back({exp_out(gb, ka - 2), exp_addr(gb, ka)});
      end
   end

   // Monitor: compares DUT outputs against the scoreboard away from the active edge.
   always @(negedge clk) begin
      logic [28:0] act_a, act_b, ea, eb;
      act_a = {a_hs, a_vs, a_de, a_r, a_g, a_b, a_vb, a_hpos, a_vpos};
      act_b = {b_hs, b_vs, b_de, b_r, b_g, b_b, b_vb, b_hpos, b_vpos};
      if (rst) begin
         check("reset_a", act_a, {16'hC000, 13'd0});
         check("reset_b", act_b, {16'hC000, 13'd0});
         qa.delete();
         qb.delete();
      end else if (qa.size() > 0 && qb.size() > 0) begin
         ea = qa.pop_front();
         eb = qb.pop_front();
         check("scan_a", act_a, ea);
         check("scan_b", act_b, eb);
         if (phase == 0) begin
            if (a_vb) vb_k.push_back(ka);
            if (!a_vs) vs_low++;
            if (!a_hs && first_hs < 0) first_hs = ka;
         end
      end
   end

   initial begin
      int v0, v1;
      rst = 1'b1;
      repeat (4) @(posedge clk);
      @(negedge clk);
      #2 rst = 1'b0;
      // Two full frames, then stop at h=100, v=40 of the third frame.
      repeat (38620) @(posedge clk);
      #2;
      phase = 1;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      #2 rst = 1'b0;
      repeat (2000) @(posedge clk);
      @(negedge clk);
      v0 = (vb_k.size() > 0) ? vb_k[0] : -1;
      v1 = (vb_k.size() > 1) ? vb_k[1] : -1;
      check("first_hs_fall", 29'(first_hs), 29'(166));
      check("vblank_count", 29'(vb_k.size()), 29'(2));
      check("vblank_first", 29'(v0), 29'(180 * 80 + 2));
      check("frame_period", 29'(v1 - v0), 29'(180 * 87));
      check("vs_low_clks", 29'(vs_low), 29'(4 * 180));
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
